// File: rtl/reg_dump_reader_pkg.sv
// Shared types for the register-dump reader: register file geometry and FSM states.
package reg_dump_reader_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int RF_DEPTH = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] rf_addr_t;
    typedef logic [DATA_W-1:0] rf_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } dump_state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Register-file read port plus the outgoing valid/ready byte stream of the dump reader.
interface reg_dump_reader_if;
    import reg_dump_reader_pkg::*;

    rf_addr_t rd_addr;
    rf_data_t rd_data;
    rf_data_t out_data;
    logic     out_valid;
    logic     out_ready;
    logic     out_last;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/reg_dump_reader.sv
// Walks an inclusive, modulo-16 register range through the file's read port and
// streams each byte out on a valid/ready channel, flagging the final byte.
//
// state | meaning
// IDLE  | waiting for start; rd_addr holds its last value
// FETCH | rd_addr presents current index; byte captured at the next edge
// SEND  | byte held on the stream until the consumer accepts it
module reg_dump_reader
    import reg_dump_reader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  rf_addr_t                 lo_addr_i,
    input  rf_addr_t                 hi_addr_i,
    output logic                     busy_o,
    output logic                     done_o,
    reg_dump_reader_if.master        bus
);

    dump_state_t state_q, state_d;
    rf_addr_t    rd_addr_q, rd_addr_d;
    rf_addr_t    rem_q, rem_d;
    rf_data_t    out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // rd_addr_q doubles as the current index; rem_q counts bytes left after this one.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rd_addr_d = lo_addr_i;
                    rem_d     = hi_addr_i - lo_addr_i;
                    busy_d    = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                out_data_d  = bus.rd_data;
                out_valid_d = 1'b1;
                out_last_d  = (rem_q == '0);
                state_d     = SEND;
            end
            SEND: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (rem_q == '0) begin
                        out_last_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        rem_d     = rem_q - ADDR_W'(1);
                        state_d   = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a behavioural 16x8 register file on the read port.
module tb_reg_dump_reader;
    import reg_dump_reader_pkg::*;

    logic     clk;
    logic     rst_n;
    logic     start;
    rf_addr_t lo_a;
    rf_addr_t hi_a;
    logic     busy;
    logic     done;
    rf_data_t rf [RF_DEPTH];

    int checks = 0;
    int errors = 0;

    reg_dump_reader_if bus ();

    assign bus.rd_data = rf[bus.rd_addr];

    reg_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .lo_addr_i (lo_a),
        .hi_addr_i (hi_a),
        .busy_o    (busy),
        .done_o    (done),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic kick(input rf_addr_t lo, input rf_addr_t hi);
        start = 1'b1;
        lo_a  = lo;
        hi_a  = hi;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge of the first FETCH cycle; returns at the negedge where done is high.
    task automatic collect(input rf_addr_t lo, input rf_addr_t hi, input bit noise, input string tag);
        rf_addr_t span;
        rf_addr_t idx;
        int n;
        int k;
        int cycles;
        bit seen;
        span   = hi - lo;
        n      = int'(span) + 1;
        k      = 0;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 100) begin
            if (bus.out_valid) begin
                idx = lo + k[3:0];
                check({tag, "_data"}, 32'(bus.out_data), 32'(rf[idx]));
                check({tag, "_addr"}, 32'(bus.rd_addr), 32'(idx));
                check({tag, "_last"}, 32'(bus.out_last), 32'(k == n - 1));
                k++;
            end
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
            end else begin
                if (noise) begin
                    start = 1'b1;
                    lo_a  = 4'd5;
                    hi_a  = 4'd9;
                end
                @(negedge clk);
                cycles++;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_count"}, 32'(k), 32'(n));
        check({tag, "_cycles"}, 32'(cycles), 32'(2 * n));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        lo_a          = '0;
        hi_a          = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < RF_DEPTH; i++) rf[i] = 8'(8'h30 + i);
        rf[0]  = 8'd22;
        rf[1]  = 8'h5A;
        rf[2]  = 8'd13;
        rf[15] = 8'd187;

        repeat (2) @(negedge clk);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Basic three-byte dump
        bus.out_ready = 1'b1;
        @(negedge clk);
        kick(4'd0, 4'd2);
        check("t1_busy_fetch", 32'(busy), 32'd1);
        check("t1_valid_fetch", 32'(bus.out_valid), 32'd0);
        collect(4'd0, 4'd2, 1'b0, "t1");
        @(negedge clk);
        check("t1_done_once", 32'(done), 32'd0);
        check("t1_addr_hold", 32'(bus.rd_addr), 32'd2);
        check("t1_valid_idle", 32'(bus.out_valid), 32'd0);

        // Full 16-byte dump
        @(negedge clk);
        kick(4'd0, 4'd15);
        collect(4'd0, 4'd15, 1'b0, "full");

        // Wrapping range 14,15,0,1
        @(negedge clk);
        kick(4'd14, 4'd1);
        collect(4'd14, 4'd1, 1'b0, "wrap");

        // Backpressure on a single-byte dump
        bus.out_ready = 1'b0;
        @(negedge clk);
        kick(4'd15, 4'd15);
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data", 32'(bus.out_data), 32'd187);
            check("bp_last", 32'(bus.out_last), 32'd1);
            check("bp_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        check("bp_valid_ready", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("bp_valid_after", 32'(bus.out_valid), 32'd0);
        check("bp_last_after", 32'(bus.out_last), 32'd0);
        check("bp_done_after", 32'(done), 32'd1);
        check("bp_busy_after", 32'(busy), 32'd0);

        // Start pulses while busy are ignored; a start on the done cycle is accepted
        @(negedge clk);
        kick(4'd0, 4'd2);
        collect(4'd0, 4'd2, 1'b1, "noise");
        kick(4'd15, 4'd15);
        check("chain_busy", 32'(busy), 32'd1);
        collect(4'd15, 4'd15, 1'b0, "chain");

        // Asynchronous reset in the middle of a full dump
        @(negedge clk);
        kick(4'd0, 4'd15);
        repeat (5) @(negedge clk);
        check("mid_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("arst_out_data", 32'(bus.out_data), 32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_last", 32'(bus.out_last), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        kick(4'd2, 4'd2);
        collect(4'd2, 4'd2, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
